// File: rtl/bfs_queue_ctrl.sv
// -----------------------------------------------------------------------------
// bfs_queue_ctrl
//
// Sequencing controller that runs a single-port 256x40 puzzle-state memory as
// a circular FIFO (the BFS open list). It is the only master of the memory
// address, write-data and write-enable lines, and it issues one memory
// operation per cycle.
//
// Operations:
//   push    - write push_data at tail in the same cycle it is accepted
//   pop     - read head, register it into pop_data, pulse pop_valid next cycle
//   lookup  - scan the live entries from head for the first match of a key
//   clear   - write zero to every address, then empty the queue
//
// Handshakes (all sampled on the rising clock edge):
//   push      : push_valid/push_ready; the push fires in a cycle where both
//               are high. push_ready is combinational and never depends on
//               push_valid.
//   pop       : pop_req is a level held until pop_valid pulses; the requester
//               drops it in the pulse cycle. A request while empty is ignored.
//   lookup    : lookup_req is a level held until lookup_done pulses and is
//               dropped in that same cycle. lookup_data is latched at accept.
//   clear     : clear_req is a level held until busy falls.
//   IDLE priority: clear_req > lookup_req > push > pop_req.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear_req                  full-memory clear request (level)
//   push_valid/push_data/push_ready   enqueue channel
//   pop_req/pop_valid/pop_data        dequeue channel
//   lookup_req/lookup_data/lookup_done/lookup_hit/lookup_idx  search channel
//   count/full/empty           occupancy
//   busy                       high while scanning or clearing
//   dbg_state                  current FSM state (IDLE=0, SCAN=1, CLEAR=2)
//   mem_addr/mem_wdata/mem_we/mem_rdata  memory port (combinational read)
//
// Configuration macro: BFS_QUEUE_INIT_CLEAR_EN
//   Defined   - the FSM leaves reset in CLEAR, so the memory is zeroed for
//               DEPTH cycles before the first push is accepted (busy resets 1).
//   Undefined - reset goes straight to IDLE (busy resets 0) and the memory
//               contents are left untouched.
// -----------------------------------------------------------------------------
module bfs_queue_ctrl #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              lookup_req,
  input  logic [DATA_W-1:0] lookup_data,
  output logic              lookup_done,
  output logic              lookup_hit,
  output logic [ADDR_W-1:0] lookup_idx,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

`ifdef BFS_QUEUE_INIT_CLEAR_EN
  localparam logic [1:0] RST_STATE = S_CLEAR;
`else
  localparam logic [1:0] RST_STATE = S_IDLE;
`endif

  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_A   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_scan_ptr;
  logic [ADDR_W:0]   r_scan_left;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] r_key;
  logic              r_pop_valid;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_lookup_done;
  logic              r_lookup_hit;
  logic [ADDR_W-1:0] r_lookup_idx;

  logic              w_idle;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ready;
  logic              w_push_fire;
  logic              w_pop_fire;
  logic              w_scan_hit;
  logic              w_scan_last;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_idle  = (r_state == S_IDLE);
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // rst_n gates the combinational strobes so nothing is offered or written
  // while reset is held, even when the reset state is CLEAR.
  assign w_push_ready = rst_n && w_idle && !w_full && !clear_req && !lookup_req;
  assign w_push_fire  = push_valid && w_push_ready;
  assign w_pop_fire   = w_idle && pop_req && !w_empty && !clear_req &&
                        !lookup_req && !w_push_fire;

  assign w_scan_hit  = (mem_rdata == r_key);
  assign w_scan_last = (r_scan_left == ONE_C);

  // Memory bus: CLEAR sweeps, SCAN walks scan_ptr, IDLE shows tail on a push
  // and head otherwise (head is what a pop reads).
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_head;
    w_mem_wdata = '0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we   = rst_n;
        w_mem_addr = r_clr_ptr;
      end
      S_SCAN: begin
        w_mem_addr = r_scan_ptr;
      end
      default: begin
        if (w_push_fire) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_tail;
          w_mem_wdata = push_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RST_STATE;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_scan_ptr    <= '0;
      r_scan_left   <= '0;
      r_clr_ptr     <= '0;
      r_key         <= '0;
      r_pop_valid   <= 1'b0;
      r_pop_data    <= '0;
      r_lookup_done <= 1'b0;
      r_lookup_hit  <= 1'b0;
      r_lookup_idx  <= '0;
    end else begin
      r_pop_valid   <= 1'b0;
      r_lookup_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
          end else if (lookup_req) begin
            r_key <= lookup_data;
            if (w_empty) begin
              // Nothing to search: answer a miss right away.
              r_lookup_done <= 1'b1;
              r_lookup_hit  <= 1'b0;
            end else begin
              r_state     <= S_SCAN;
              r_scan_ptr  <= r_head;
              r_scan_left <= r_count;
            end
          end else if (w_push_fire) begin
            r_tail  <= r_tail + ONE_A;
            r_count <= r_count + ONE_C;
          end else if (w_pop_fire) begin
            r_pop_data  <= mem_rdata;
            r_pop_valid <= 1'b1;
            r_head      <= r_head + ONE_A;
            r_count     <= r_count - ONE_C;
          end
        end
        S_SCAN: begin
          if (w_scan_hit) begin
            r_lookup_done <= 1'b1;
            r_lookup_hit  <= 1'b1;
            r_lookup_idx  <= r_scan_ptr;
            r_state       <= S_IDLE;
          end else if (w_scan_last) begin
            r_lookup_done <= 1'b1;
            r_lookup_hit  <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_scan_ptr  <= r_scan_ptr + ONE_A;
            r_scan_left <= r_scan_left - ONE_C;
          end
        end
        S_CLEAR: begin
          if (r_clr_ptr == LAST_A) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
          end else begin
            r_clr_ptr <= r_clr_ptr + ONE_A;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign push_ready  = w_push_ready;
  assign pop_valid   = r_pop_valid;
  assign pop_data    = r_pop_data;
  assign lookup_done = r_lookup_done;
  assign lookup_hit  = r_lookup_hit;
  assign lookup_idx  = r_lookup_idx;
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign busy        = (r_state == S_SCAN) || (r_state == S_CLEAR);
  assign dbg_state   = r_state;
  assign mem_addr    = w_mem_addr;
  assign mem_wdata   = w_mem_wdata;
  assign mem_we      = w_mem_we;

endmodule
